// File: rtl/nios2_system_onchip_ram_if.sv
// Avalon-style slave bus for the on-chip RAM: request, clock enable and response signals.
interface nios2_system_onchip_ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    clken;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;
    logic                    init_done;

    modport master (
        output chipselect, read, write, address, byteenable, writedata, clken,
        input  readdata, readdatavalid, waitrequest, init_done
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata, clken,
        output readdata, readdatavalid, waitrequest, init_done
    );
endinterface

// File: rtl/nios2_system_onchip_ram.sv
// Single-port on-chip RAM with byte enables, optional zero-fill after reset,
// clock-enable stall and a 1- or 2-cycle pipelined read path.
module nios2_system_onchip_ram #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic                     clk,
    input logic                     reset_n,
    nios2_system_onchip_ram_if.slave bus
);
    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic                    rst_sync_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    clr_we;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    accept, rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;

    // Reset release is seen by the FSM one clock after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    // Next-state logic: leave reset, sweep the clear counter, then serve traffic.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        unique case (state_q)
            StReset: begin
                if (rst_sync_q) begin
                    state_d = CLEAR_ON_RESET ? StClear : StReady;
                end
            end
            StClear: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: state_d = StReset;
        endcase
        // clken low freezes the sequencer entirely.
        if (!bus.clken) begin
            state_d   = state_q;
            clr_cnt_d = clr_cnt_q;
            clr_we    = 1'b0;
        end
    end

    // FSM state and clear counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StReset;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign accept = (state_q == StReady) & bus.clken & bus.chipselect & (bus.read | bus.write);
    assign wr_acc = accept & bus.write;
    // A read that coincides with a write is dropped.
    assign rd_acc = accept & bus.read & ~bus.write;

    assign bus.waitrequest = (state_q != StReady) | ~bus.clken;
    assign bus.init_done   = (state_q == StReady);

    // Storage: zero fill while clearing, byte-masked writes when ready; never reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (bus.byteenable[b]) begin
                    mem_q[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic                  s1_valid_q;

        // Two-stage read pipeline, advanced only while clken is high.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
                rdata_q    <= '0;
                rvalid_q   <= 1'b0;
            end else if (bus.clken) begin
                s1_valid_q <= rd_acc;
                if (rd_acc) begin
                    s1_data_q <= mem_q[bus.address];
                end
                rvalid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rdata_q <= s1_data_q;
                end
            end
        end
    end else begin : g_lat1
        // Single-stage read pipeline, advanced only while clken is high.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (bus.clken) begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem_q[bus.address];
                end
            end
        end
    end

    assign bus.readdata = rdata_q;
    // A response that lands during a stall is held back until clken returns.
    assign bus.readdatavalid = rvalid_q & bus.clken;

endmodule
